if_mem_port_arbiter: RTL and testbench
======================================

// Module: if_mem_port_arbiter
// PURPOSE
// Shares one single-port instruction/data memory between instruction fetch and the MEM stage.
// Sequences multi-cycle accesses and generates if_freeze (drives ~ld of PC reg and IF stage reg) and mem_stall (freezes the whole pipeline).
// Buffers a fetched instruction that completes while the pipeline is stalled. Discards a fetch made stale by a taken branch.
// PARAMETERS
// LATENCY  4  cycles per memory access (>=1); access occupies state for exactly LATENCY cycles
// CNT_W    3  access counter width; must satisfy 2**CNT_W >= LATENCY
// PORTS
// CLK          in   1   clock, all state on posedge
// RST          in   1   synchronous active-high reset
// if_req       in   1   fetch wanted (tied high in normal flow)
// if_addr      in   32  current PC, live (not latched)
// branch_taken in   1   taken branch from EXE; accepted only in cycles with mem_stall=0
// mem_rd_req   in   1   MEM-stage load, held until mem_stall falls
// mem_wr_req   in   1   MEM-stage store, held until mem_stall falls
// mem_addr     in   32  load/store address
// mem_wdata    in   32  store data
// mport_start  out  1   first cycle of an access; addr/we/wdata valid only in this cycle
// mport_we     out  1   write strobe, qualified by mport_start
// mport_addr   out  32  access address
// mport_wdata  out  32  write data
// mport_rdata  in   32  read data, valid in last cycle of an access
// if_inst      out  32  instruction to the IF stage register; valid when if_freeze=0
// if_freeze    out  1   1 = hold PC and the IF stage register
// mem_rdata    out  32  load data; valid in the cycle mem_stall falls
// mem_stall    out  1   1 = hold the entire pipeline
// BEHAVIOUR
// - State: st in {IDLE, FETCH, DATA}, cnt[CNT_W-1:0], stale (1b), buf_valid (1b), inst_buf (32b).
// - Reset (RST=1 at posedge): st=IDLE, cnt=0, stale=0, buf_valid=0, inst_buf=0. Any in-flight access is abandoned.
// - mem_req = mem_rd_req|mem_wr_req. last = (st!=IDLE)&&(cnt==LATENCY-1).
// - cnt: 0 on entering FETCH/DATA; +1 each cycle in FETCH/DATA; back to 0 on the last cycle. Never exceeds LATENCY-1.
// - IDLE: mem_req -> DATA (MEM has priority); else if_req -> FETCH; else stay.
// - FETCH, last cycle: mem_req -> DATA; else if_req -> FETCH; else IDLE. Not last: stay. No preemption.
// - DATA, last cycle: if_req -> FETCH; else IDLE. Not last: stay.
// - mport_start = (st!=IDLE)&&(cnt==0).
// - mport_addr = FETCH ? if_addr : mem_addr.
// - mport_we = (st==DATA)&&mem_wr_req&&mport_start.
// - mport_wdata = mem_wdata.
// - mem_stall = mem_req && !(st==DATA && last). mem_rdata = mport_rdata, combinational passthrough.
// - fetch_done = (st==FETCH)&&last&&!stale.
// - if_freeze = 0 iff mem_stall==0 && (branch_taken | buf_valid | fetch_done); else 1.
// - if_inst = buf_valid ? inst_buf : mport_rdata.
// - fetch_done while mem_stall=1: inst_buf <= mport_rdata, buf_valid <= 1.
// - While buf_valid=1, no FETCH is started. Buffer is released the first cycle mem_stall=0 (if_freeze=0), then buf_valid <= 0.
// - Branch accepted (branch_taken & !mem_stall): if_freeze=0 that cycle so PC loads the target and the IF register flushes.
//   - st==FETCH and not last: stale <= 1.
//   - Stale completion: result dropped, if_freeze stays 1, stale <= 0, normal transition.
//   - Branch in the fetch_done or buffer-release cycle: no stale; the instruction passes and is flushed downstream.
// - Loads/stores are never reordered. mem_req is sampled live each cycle; the pipeline holds it stable.
// - Throughput with no MEM traffic: one instruction per LATENCY cycles after a single IDLE cycle out of reset.
// TESTING
// 1 LATENCY=4, RST 1->0 at c0, if_req=1: IDLE c0; mport_start at c1,c5,c9 with addr=PC; if_freeze=0 only at c4,c8,c12.
// 2 As 1 plus mem_rd_req=1 from c2:
//   - mem_stall=1 c2-c7, 0 at c8 with mem_rdata=mport_rdata.
//   - Fetch done c4 buffered (if_freeze=1); DATA c5-c8.
//   - c8: if_freeze=0, if_inst=buffered word. Next mport_start at c9.
// 3 As 1 with branch_taken at c2:
//   - if_freeze=0 at c2; c4 completion dropped (if_freeze=1).
//   - mport_start c5 with addr=branch target; if_freeze=0 at c8.
// 4 if_req=0, mem_wr_req=1, addr=0x40, wdata=0xDEADBEEF at c0: DATA c1-c4; mport_we=1 only c1; mem_stall falls c4.
// 5 RST=1 at c3 mid-fetch: c4 st=IDLE, buf_valid=0, stale=0; no if_freeze=0 pulse until new fetch completes at c8.
// 6 LATENCY=1, if_req=1: if_freeze=0 every cycle from c1; mem_rd_req one access: mem_stall=1 exactly 1 cycle, no instruction lost.

Source files
------------

// File: rtl/if_mem_port_arbiter_if.sv
// Bundle of the pipeline-side and memory-side signals of the shared memory port arbiter.
// The slave modport is the arbiter's view of the bundle; the master modport is the view of the pipeline and the memory.
interface if_mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        branch_taken;
   logic        mem_rd_req;
   logic        mem_wr_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mport_start;
   logic        mport_we;
   logic [31:0] mport_addr;
   logic [31:0] mport_wdata;
   logic [31:0] mport_rdata;
   logic [31:0] if_inst;
   logic        if_freeze;
   logic [31:0] mem_rdata;
   logic        mem_stall;

   modport slave (
      input  if_req, if_addr, branch_taken, mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
      input  mport_rdata,
      output mport_start, mport_we, mport_addr, mport_wdata,
      output if_inst, if_freeze, mem_rdata, mem_stall
   );

   modport master (
      output if_req, if_addr, branch_taken, mem_rd_req, mem_wr_req, mem_addr, mem_wdata,
      output mport_rdata,
      input  mport_start, mport_we, mport_addr, mport_wdata,
      input  if_inst, if_freeze, mem_rdata, mem_stall
   );
endinterface

// File: rtl/if_mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the MEM stage,
// producing if_freeze / mem_stall and buffering a fetch that completes under a stall.
module if_mem_port_arbiter #(
   parameter int LATENCY = 4,
   parameter int CNT_W   = 3
) (
   input  logic                CLK,
   input  logic                RST,
   if_mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2
   } st_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   st_t              st_reg, st_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             stale_reg, stale_next;
   logic             buf_valid_reg, buf_valid_next;
   logic [31:0]      inst_buf_reg, inst_buf_next;

   logic mem_req;
   logic last;
   logic stall;
   logic fetch_done;
   logic can_fetch;

   assign mem_req    = bus.mem_rd_req | bus.mem_wr_req;
   assign last       = (st_reg != IDLE) && (cnt_reg == CNT_LAST);
   assign stall      = mem_req && !((st_reg == DATA) && last);
   assign fetch_done = (st_reg == FETCH) && last && !stale_reg;
   // A fetch may begin only if the buffer will be empty from the next cycle on.
   assign can_fetch  = bus.if_req && !buf_valid_next;

   always_ff @(posedge CLK) begin
      if (RST) begin
         st_reg        <= IDLE;
         cnt_reg       <= '0;
         stale_reg     <= 1'b0;
         buf_valid_reg <= 1'b0;
         inst_buf_reg  <= '0;
      end else begin
         st_reg        <= st_next;
         cnt_reg       <= cnt_next;
         stale_reg     <= stale_next;
         buf_valid_reg <= buf_valid_next;
         inst_buf_reg  <= inst_buf_next;
      end
   end

   always_comb begin
      buf_valid_next = buf_valid_reg;
      inst_buf_next  = inst_buf_reg;
      if (fetch_done && stall) begin
         buf_valid_next = 1'b1;
         inst_buf_next  = bus.mport_rdata;
      end else if (buf_valid_reg && !stall) begin
         buf_valid_next = 1'b0;
      end
   end

   always_comb begin
      st_next    = st_reg;
      cnt_next   = cnt_reg;
      stale_next = stale_reg;
      case (st_reg)
         IDLE: begin
            cnt_next = '0;
            if (mem_req)        st_next = DATA;
            else if (can_fetch) st_next = FETCH;
         end
         FETCH: begin
            if (last) begin
               cnt_next   = '0;
               stale_next = 1'b0;
               if (mem_req)        st_next = DATA;
               else if (can_fetch) st_next = FETCH;
               else                st_next = IDLE;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
               // A branch redirects the PC mid-fetch, so this fetch's word is dropped.
               if (bus.branch_taken && !stall) stale_next = 1'b1;
            end
         end
         DATA: begin
            if (last) begin
               cnt_next = '0;
               if (can_fetch) st_next = FETCH;
               else           st_next = IDLE;
            end else begin
               cnt_next = cnt_reg + CNT_ONE;
            end
         end
         default: begin
            st_next  = IDLE;
            cnt_next = '0;
         end
      endcase
   end

   assign bus.mport_start = (st_reg != IDLE) && (cnt_reg == '0);
   assign bus.mport_addr  = (st_reg == FETCH) ? bus.if_addr : bus.mem_addr;
   assign bus.mport_we    = (st_reg == DATA) && bus.mem_wr_req && bus.mport_start;
   assign bus.mport_wdata = bus.mem_wdata;
   assign bus.mem_stall   = stall;
   assign bus.mem_rdata   = bus.mport_rdata;
   assign bus.if_freeze   = !(!stall && (bus.branch_taken || buf_valid_reg || fetch_done));
   assign bus.if_inst     = buf_valid_reg ? inst_buf_reg : bus.mport_rdata;

endmodule

// File: tb/tb_if_mem_port_arbiter.sv
// Self-checking bench for if_mem_port_arbiter: directed timing scenarios on LATENCY=4 and LATENCY=1
// instances, then randomized pipeline traffic compared against a cycle-stamped access model.
module tb_if_mem_port_arbiter;

   localparam int L4 = 4;

   logic clk = 1'b0;
   logic rst4, rst1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   if_mem_port_arbiter_if b4();
   if_mem_port_arbiter_if b1();

   if_mem_port_arbiter #(.LATENCY(4), .CNT_W(3)) dut4 (.CLK(clk), .RST(rst4), .bus(b4));
   if_mem_port_arbiter #(.LATENCY(1), .CNT_W(1)) dut1 (.CLK(clk), .RST(rst1), .bus(b1));

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
   endfunction

   // Memory stand-in: latches the address on the start cycle and returns memf(addr).
   logic [31:0] cap4 = 32'h0;
   logic [31:0] cap1 = 32'h0;
   always @(posedge clk) begin
      if (b4.mport_start) cap4 <= b4.mport_addr;
      if (b1.mport_start) cap1 <= b1.mport_addr;
   end
   assign b4.mport_rdata = b4.mport_start ? memf(b4.mport_addr) : memf(cap4);
   assign b1.mport_rdata = b1.mport_start ? memf(b1.mport_addr) : memf(cap1);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      b4.if_req = 0; b4.if_addr = 0; b4.branch_taken = 0;
      b4.mem_rd_req = 0; b4.mem_wr_req = 0; b4.mem_addr = 0; b4.mem_wdata = 0;
      b1.if_req = 0; b1.if_addr = 0; b1.branch_taken = 0;
      b1.mem_rd_req = 0; b1.mem_wr_req = 0; b1.mem_addr = 0; b1.mem_wdata = 0;
   endtask

   // Leaves the bench one delta into cycle c0, the first cycle with reset released.
   task automatic do_reset();
      rst4 = 1'b1; rst1 = 1'b1;
      tick();
      rst4 = 1'b0; rst1 = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      do_reset();
      for (int c = 0; c < 2; c++) begin
         #1;
         vectors++;
         if (b4.mport_start !== 1'b0) begin
            miscompares++; $display("FAIL reset c%0d start4: got %b expected 0", c, b4.mport_start);
         end
         vectors++;
         if (b4.if_freeze !== 1'b1 || b4.mem_stall !== 1'b0) begin
            miscompares++; $display("FAIL reset c%0d freeze/stall4: got %b/%b expected 1/0", c, b4.if_freeze, b4.mem_stall);
         end
         vectors++;
         if (b1.mport_start !== 1'b0 || b1.if_freeze !== 1'b1 || b1.mem_stall !== 1'b0) begin
            miscompares++; $display("FAIL reset c%0d dut1: got start=%b freeze=%b stall=%b expected 0/1/0", c, b1.mport_start, b1.if_freeze, b1.mem_stall);
         end
         tick();
      end
   endtask

   task automatic test_fetch_stream();
      logic [31:0] pc;
      bit es, ef;
      clear_inputs();
      do_reset();
      pc = 32'h100;
      b4.if_req = 1;
      for (int c = 0; c <= 12; c++) begin
         b4.if_addr = pc;
         #1;
         es = (c == 1 || c == 5 || c == 9);
         ef = !(c == 4 || c == 8 || c == 12);
         vectors++;
         if (b4.mport_start !== es) begin
            miscompares++; $display("FAIL fetch_stream c%0d start: got %b expected %b", c, b4.mport_start, es);
         end
         if (es) begin
            vectors++;
            if (b4.mport_addr !== pc) begin
               miscompares++; $display("FAIL fetch_stream c%0d addr: got %h expected %h", c, b4.mport_addr, pc);
            end
         end
         vectors++;
         if (b4.if_freeze !== ef) begin
            miscompares++; $display("FAIL fetch_stream c%0d freeze: got %b expected %b", c, b4.if_freeze, ef);
         end
         if (!ef) begin
            vectors++;
            if (b4.if_inst !== memf(pc)) begin
               miscompares++; $display("FAIL fetch_stream c%0d inst: got %h expected %h", c, b4.if_inst, memf(pc));
            end
         end
         if (b4.if_freeze === 1'b0) pc = pc + 4;
         tick();
      end
   endtask

   task automatic test_load_during_fetch();
      logic [31:0] pc, ea;
      bit es, ef, est;
      clear_inputs();
      do_reset();
      pc = 32'h200;
      b4.if_req = 1;
      b4.mem_addr = 32'h3000;
      for (int c = 0; c <= 12; c++) begin
         b4.if_addr = pc;
         b4.mem_rd_req = (c >= 2 && c <= 8);
         #1;
         es  = (c == 1 || c == 5 || c == 9);
         ea  = (c == 5) ? 32'h3000 : pc;
         ef  = !(c == 8 || c == 12);
         est = (c >= 2 && c <= 7);
         vectors++;
         if (b4.mem_stall !== est) begin
            miscompares++; $display("FAIL load c%0d stall: got %b expected %b", c, b4.mem_stall, est);
         end
         vectors++;
         if (b4.mport_start !== es) begin
            miscompares++; $display("FAIL load c%0d start: got %b expected %b", c, b4.mport_start, es);
         end
         if (es) begin
            vectors++;
            if (b4.mport_addr !== ea || b4.mport_we !== 1'b0) begin
               miscompares++; $display("FAIL load c%0d addr/we: got %h/%b expected %h/0", c, b4.mport_addr, b4.mport_we, ea);
            end
         end
         vectors++;
         if (b4.if_freeze !== ef) begin
            miscompares++; $display("FAIL load c%0d freeze: got %b expected %b", c, b4.if_freeze, ef);
         end
         if (!ef) begin
            vectors++;
            if (b4.if_inst !== memf(pc)) begin
               miscompares++; $display("FAIL load c%0d inst: got %h expected %h", c, b4.if_inst, memf(pc));
            end
         end
         if (c == 8) begin
            vectors++;
            if (b4.mem_rdata !== memf(32'h3000)) begin
               miscompares++; $display("FAIL load c%0d rdata: got %h expected %h", c, b4.mem_rdata, memf(32'h3000));
            end
         end
         if (b4.if_freeze === 1'b0) pc = pc + 4;
         tick();
      end
   endtask

   task automatic test_branch();
      logic [31:0] pc, tgt;
      bit es, ef;
      clear_inputs();
      do_reset();
      pc  = 32'h300;
      tgt = 32'h800;
      b4.if_req = 1;
      for (int c = 0; c <= 12; c++) begin
         b4.if_addr = pc;
         b4.branch_taken = (c == 2);
         #1;
         es = (c == 1 || c == 5 || c == 9);
         ef = !(c == 2 || c == 8 || c == 12);
         vectors++;
         if (b4.mport_start !== es) begin
            miscompares++; $display("FAIL branch c%0d start: got %b expected %b", c, b4.mport_start, es);
         end
         if (c == 5 || c == 9) begin
            vectors++;
            if (b4.mport_addr !== ((c == 5) ? tgt : tgt + 4)) begin
               miscompares++; $display("FAIL branch c%0d addr: got %h expected %h", c, b4.mport_addr, (c == 5) ? tgt : tgt + 4);
            end
         end
         vectors++;
         if (b4.if_freeze !== ef) begin
            miscompares++; $display("FAIL branch c%0d freeze: got %b expected %b", c, b4.if_freeze, ef);
         end
         if (!ef && c != 2) begin
            vectors++;
            if (b4.if_inst !== memf(pc)) begin
               miscompares++; $display("FAIL branch c%0d inst: got %h expected %h", c, b4.if_inst, memf(pc));
            end
         end
         if (b4.if_freeze === 1'b0) pc = (c == 2) ? tgt : pc + 4;
         tick();
      end
      b4.branch_taken = 0;
   endtask

   task automatic test_store();
      bit es, est;
      clear_inputs();
      do_reset();
      b4.mem_addr  = 32'h40;
      b4.mem_wdata = 32'hDEAD_BEEF;
      for (int c = 0; c <= 6; c++) begin
         b4.mem_wr_req = (c <= 4);
         #1;
         es  = (c == 1);
         est = (c <= 3);
         vectors++;
         if (b4.mport_start !== es || b4.mport_we !== es) begin
            miscompares++; $display("FAIL store c%0d start/we: got %b/%b expected %b/%b", c, b4.mport_start, b4.mport_we, es, es);
         end
         if (es) begin
            vectors++;
            if (b4.mport_addr !== 32'h40 || b4.mport_wdata !== 32'hDEAD_BEEF) begin
               miscompares++; $display("FAIL store c%0d addr/wdata: got %h/%h expected 00000040/deadbeef", c, b4.mport_addr, b4.mport_wdata);
            end
         end
         vectors++;
         if (b4.mem_stall !== est || b4.if_freeze !== 1'b1) begin
            miscompares++; $display("FAIL store c%0d stall/freeze: got %b/%b expected %b/1", c, b4.mem_stall, b4.if_freeze, est);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] pc;
      bit es, ef;
      clear_inputs();
      do_reset();
      pc = 32'h500;
      b4.if_req = 1;
      for (int c = 0; c <= 9; c++) begin
         b4.if_addr = pc;
         rst4 = (c == 3);
         #1;
         es = (c == 1 || c == 5 || c == 9);
         ef = (c != 8);
         vectors++;
         if (b4.mport_start !== es) begin
            miscompares++; $display("FAIL reset_mid c%0d start: got %b expected %b", c, b4.mport_start, es);
         end
         vectors++;
         if (b4.if_freeze !== ef) begin
            miscompares++; $display("FAIL reset_mid c%0d freeze: got %b expected %b", c, b4.if_freeze, ef);
         end
         if (!ef) begin
            vectors++;
            if (b4.if_inst !== memf(pc)) begin
               miscompares++; $display("FAIL reset_mid c%0d inst: got %h expected %h", c, b4.if_inst, memf(pc));
            end
         end
         if (b4.if_freeze === 1'b0) pc = pc + 4;
         tick();
      end
      rst4 = 1'b0;
   endtask

   task automatic test_latency1();
      logic [31:0] pc;
      bit ef, est, pend;
      clear_inputs();
      do_reset();
      pc = 32'h0;
      pend = 0;
      b1.if_req = 1;
      b1.mem_addr = 32'h7700;
      for (int c = 0; c <= 15; c++) begin
         if (c == 6) pend = 1;
         b1.if_addr = pc;
         b1.mem_rd_req = pend;
         #1;
         ef  = (c == 0 || c == 6);
         est = (c == 6);
         vectors++;
         if (b1.mem_stall !== est) begin
            miscompares++; $display("FAIL lat1 c%0d stall: got %b expected %b", c, b1.mem_stall, est);
         end
         vectors++;
         if (b1.if_freeze !== ef) begin
            miscompares++; $display("FAIL lat1 c%0d freeze: got %b expected %b", c, b1.if_freeze, ef);
         end
         if (!ef) begin
            vectors++;
            if (b1.if_inst !== memf(pc)) begin
               miscompares++; $display("FAIL lat1 c%0d inst: got %h expected %h", c, b1.if_inst, memf(pc));
            end
         end
         if (c == 7) begin
            vectors++;
            if (b1.mem_rdata !== memf(32'h7700)) begin
               miscompares++; $display("FAIL lat1 c%0d rdata: got %h expected %h", c, b1.mem_rdata, memf(32'h7700));
            end
         end
         if (pend && b1.mem_stall === 1'b0) pend = 0;
         if (b1.if_freeze === 1'b0) pc = pc + 4;
         tick();
      end
      vectors++;
      if (pc !== 32'd56) begin
         miscompares++; $display("FAIL lat1 delivered: got %0d instructions expected 14", pc / 4);
      end
   endtask

   // Reference: each access is stamped with its start cycle and ends LATENCY cycles later;
   // instructions that finish under a stall wait in a queue for the first unstalled cycle.
   task automatic test_random(input int ncyc);
      logic [31:0] pc, tmp, tgt, p_addr, p_wdata, m_addr, ei, ea;
      logic [31:0] q[$];
      bit pend, p_wr, br, ireq, rd, wr, busy, fin, es, est, ef, got, mreq, ewe, stale;
      int kind, m_start, age;
      clear_inputs();
      do_reset();
      pc = 32'h1000; pend = 0; p_wr = 0; p_addr = 0; p_wdata = 0;
      kind = 0; m_start = 0; stale = 0; m_addr = 0;
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         ireq = ($urandom_range(0, 9) != 0);
         br   = ($urandom_range(0, 7) == 0);
         tmp  = $urandom;
         tgt  = tmp & 32'hFFFF_FFFC;
         if (!pend && $urandom_range(0, 3) == 0) begin
            pend    = 1;
            p_wr    = ($urandom_range(0, 1) == 1);
            tmp     = $urandom;
            p_addr  = tmp & 32'hFFFF_FFFC;
            p_wdata = $urandom;
         end
         rd = pend && !p_wr;
         wr = pend && p_wr;
         b4.if_req = ireq; b4.if_addr = pc; b4.branch_taken = br;
         b4.mem_rd_req = rd; b4.mem_wr_req = wr; b4.mem_addr = p_addr; b4.mem_wdata = p_wdata;
         #1;
         busy = (kind != 0);
         age  = cyc - m_start;
         fin  = busy && (age == L4 - 1);
         es   = busy && (age == 0);
         if (es && kind == 1) m_addr = pc;
         mreq = rd || wr;
         est  = mreq && !(kind == 2 && fin);
         got  = (kind == 1) && fin && !stale;
         ef   = !(!est && (br || q.size() != 0 || got));
         ewe  = (kind == 2) && wr && es;
         ea   = (kind == 1) ? pc : p_addr;
         vectors++;
         if (b4.mport_start !== es || b4.mport_we !== ewe) begin
            miscompares++; $display("FAIL random cyc%0d start/we: got %b/%b expected %b/%b", cyc, b4.mport_start, b4.mport_we, es, ewe);
         end
         if (es) begin
            vectors++;
            if (b4.mport_addr !== ea) begin
               miscompares++; $display("FAIL random cyc%0d addr: got %h expected %h", cyc, b4.mport_addr, ea);
            end
         end
         if (ewe) begin
            vectors++;
            if (b4.mport_wdata !== p_wdata) begin
               miscompares++; $display("FAIL random cyc%0d wdata: got %h expected %h", cyc, b4.mport_wdata, p_wdata);
            end
         end
         vectors++;
         if (b4.mem_stall !== est || b4.if_freeze !== ef) begin
            miscompares++; $display("FAIL random cyc%0d stall/freeze: got %b/%b expected %b/%b", cyc, b4.mem_stall, b4.if_freeze, est, ef);
         end
         if (!ef && (q.size() != 0 || got)) begin
            ei = (q.size() != 0) ? q[0] : memf(m_addr);
            vectors++;
            if (b4.if_inst !== ei) begin
               miscompares++; $display("FAIL random cyc%0d inst: got %h expected %h", cyc, b4.if_inst, ei);
            end
         end
         if (kind == 2 && fin && rd) begin
            vectors++;
            if (b4.mem_rdata !== memf(p_addr)) begin
               miscompares++; $display("FAIL random cyc%0d rdata: got %h expected %h", cyc, b4.mem_rdata, memf(p_addr));
            end
         end
         if (got && est)                  q.push_back(memf(m_addr));
         else if (q.size() != 0 && !est)  void'(q.pop_front());
         if (kind == 1 && fin)                  stale = 0;
         else if (kind == 1 && br && !est)      stale = 1;
         if (!busy || fin) begin
            if (mreq && kind != 2) begin
               kind = 2; m_start = cyc + 1;
            end else if (ireq && q.size() == 0) begin
               kind = 1; m_start = cyc + 1;
            end else begin
               kind = 0;
            end
         end
         if (!ef) pc = br ? tgt : pc + 4;
         if (pend && !est) pend = 0;
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      rst4 = 1'b1;
      rst1 = 1'b1;
      clear_inputs();
      test_reset();
      test_fetch_stream();
      test_load_during_fetch();
      test_branch();
      test_store();
      test_reset_mid();
      test_latency1();
      test_random(3000);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
